// File: rtl/addsub_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_op_sequencer
//  Purpose  : Issue stage for the signed add/sub unit. Queues (mode, A, B)
//             requests, issues one at a time, waits the unit latency, then
//             hands the result and a signed-overflow flag downstream.
//  Revision : 1.0  initial release
// ============================================================================
module addsub_op_sequencer #(
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int RESULT_LATENCY  = 1
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               InValid,
    output logic                               InReady,
    input  logic                               InMode,
    input  logic [INPUT_BIT_WIDTH-1:0]         InA,
    input  logic [INPUT_BIT_WIDTH-1:0]         InB,
    output logic                               AddSubMode,
    output logic [INPUT_BIT_WIDTH-1:0]         OpA,
    output logic [INPUT_BIT_WIDTH-1:0]         OpB,
    input  logic [INPUT_BIT_WIDTH-1:0]         AddSubResult,
    output logic                               OutValid,
    input  logic                               OutReady,
    output logic [INPUT_BIT_WIDTH-1:0]         OutResult,
    output logic                               OutOverflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    Count
);

    localparam int c_W     = INPUT_BIT_WIDTH;
    localparam int c_ENT_W = 2 * c_W + 1;
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_LAT_W = (RESULT_LATENCY > 0) ? $clog2(RESULT_LATENCY + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_LAT_W-1:0] r_lat;

    logic               r_mode;
    logic [c_W-1:0]     r_opa;
    logic [c_W-1:0]     r_opb;
    logic [c_W-1:0]     r_result;
    logic               r_ovf;
    logic               r_valid;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_capture;
    logic [c_ENT_W-1:0] w_head;
    logic               w_ovf;
    logic               w_msb_a;
    logic               w_msb_b;
    logic               w_msb_r;

    // Fullness comes from the registered count only, so a pop on the same
    // edge never opens room for a push into a full FIFO.
    assign w_full  = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign InReady = ~w_full;
    assign w_push  = InValid & ~w_full;
    assign w_head  = r_mem[r_rptr];

    // Signed overflow judged from the operands actually issued to the unit.
    assign w_msb_a = r_opa[c_W-1];
    assign w_msb_b = r_opb[c_W-1];
    assign w_msb_r = AddSubResult[c_W-1];
    assign w_ovf   = r_mode ? ((w_msb_a == w_msb_b) && (w_msb_r != w_msb_a))
                            : ((w_msb_a != w_msb_b) && (w_msb_r != w_msb_a));

    assign AddSubMode  = r_mode;
    assign OpA         = r_opa;
    assign OpB         = r_opb;
    assign OutValid    = r_valid;
    assign OutResult   = r_result;
    assign OutOverflow = r_ovf;
    assign Count       = r_count;

    // Request storage; entries need no reset since count gates every read.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {InMode, InA, InB};
        end
    end

    // FIFO pointers and occupancy; power-of-two depth wraps naturally.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state plus the pop/capture strobes that drive the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_lat == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (OutReady) begin
                    if (r_count != '0) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latency countdown: loaded on issue, decremented while waiting.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_lat <= '0;
        end else if (w_pop) begin
            r_lat <= c_LAT_W'(RESULT_LATENCY);
        end else if ((r_state == S_WAIT) && (r_lat != '0)) begin
            r_lat <= r_lat - c_LAT_W'(1);
        end
    end

    // Operand issue and result capture; operands persist until the next pop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mode   <= 1'b0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_mode <= w_head[c_ENT_W-1];
                r_opa  <= w_head[2*c_W-1:c_W];
                r_opb  <= w_head[c_W-1:0];
            end
            if (w_capture) begin
                r_result <= AddSubResult;
                r_ovf    <= w_ovf;
                r_valid  <= 1'b1;
            end else if ((r_state == S_HOLD) && OutReady) begin
                r_valid  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_addsub_op_sequencer
//  Purpose  : Self-checking bench for addsub_op_sequencer with a registered
//             add/sub unit model (latency 1), directed tables and random ops.
//  Revision : 1.0  initial release
// ============================================================================
module tb_addsub_op_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       InValid;
    logic       InReady;
    logic       InMode;
    logic [7:0] InA;
    logic [7:0] InB;
    logic       AddSubMode;
    logic [7:0] OpA;
    logic [7:0] OpB;
    logic [7:0] AddSubResult = 8'd0;
    logic       OutValid;
    logic       OutReady;
    logic [7:0] OutResult;
    logic       OutOverflow;
    logic [2:0] Count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       ovf;
    } exp_t;

    vec_t tbl [9];
    exp_t exp_q [$];

    addsub_op_sequencer #(
        .INPUT_BIT_WIDTH (8),
        .FIFO_DEPTH      (4),
        .RESULT_LATENCY  (1)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .InValid      (InValid),
        .InReady      (InReady),
        .InMode       (InMode),
        .InA          (InA),
        .InB          (InB),
        .AddSubMode   (AddSubMode),
        .OpA          (OpA),
        .OpB          (OpB),
        .AddSubResult (AddSubResult),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .OutResult    (OutResult),
        .OutOverflow  (OutOverflow),
        .Count        (Count)
    );

    always #5 Clk = ~Clk;

    // Add/sub unit stand-in: result registered one edge after operands.
    always @(posedge Clk) begin
        AddSubResult <= AddSubMode ? (OpA + OpB) : (OpA - OpB);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion", nm);
    endtask

    // Reference: exact integer arithmetic, overflow = outside 8-bit signed range.
    function automatic exp_t ref_op(input logic m, input logic signed [7:0] a,
                                    input logic signed [7:0] b);
        int   r;
        exp_t e;
        r     = m ? (int'(a) + int'(b)) : (int'(a) - int'(b));
        e.res = r[7:0];
        e.ovf = (r > 127) || (r < -128);
        return e;
    endfunction

    task automatic push_one(input logic m, input logic [7:0] a, input logic [7:0] b,
                            input exp_t e);
        logic rs;
        int   n;
        n       = 0;
        InValid = 1'b1;
        InMode  = m;
        InA     = a;
        InB     = b;
        do begin
            rs = InReady;
            tick();
            n++;
        end while (!rs && n < 500);
        InValid = 1'b0;
        if (rs) exp_q.push_back(e);
        else    fail("push_timeout");
    endtask

    task automatic collect(input int n, input bit rnd);
        int         got;
        int         cyc;
        logic       rdy;
        logic       hold;
        logic [7:0] hr;
        logic       ho;
        exp_t       e;
        got  = 0;
        cyc  = 0;
        hold = 1'b0;
        hr   = '0;
        ho   = 1'b0;
        while (got < n && cyc < 5000) begin
            if (hold) begin
                chk("hold_valid", int'(OutValid), 1);
                chk("hold_result", int'(OutResult), int'(hr));
                chk("hold_ovf", int'(OutOverflow), int'(ho));
            end
            rdy      = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            OutReady = rdy;
            hold     = OutValid && !rdy;
            hr       = OutResult;
            ho       = OutOverflow;
            if (OutValid && rdy) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_result");
                end else begin
                    e = exp_q.pop_front();
                    chk("result", int'(OutResult), int'(e.res));
                    chk("overflow", int'(OutOverflow), int'(e.ovf));
                end
                got++;
            end
            tick();
            cyc++;
        end
        if (got < n) fail("collect_timeout");
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, int'(OutValid), 0);
        chk({tag, "_count"}, int'(Count), 0);
        chk({tag, "_inready"}, int'(InReady), 1);
        chk({tag, "_mode"}, int'(AddSubMode), 0);
        chk({tag, "_opa"}, int'(OpA), 0);
        chk({tag, "_opb"}, int'(OpB), 0);
        chk({tag, "_result"}, int'(OutResult), 0);
        chk({tag, "_ovf"}, int'(OutOverflow), 0);
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!OutValid && n < 20) begin
            tick();
            n++;
        end
        if (!OutValid) fail(nm);
    endtask

    task automatic no_output_for(input string nm, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (OutValid) seen = 1'b1;
        end
        chk(nm, int'(seen), 0);
    endtask

    initial begin
        logic       acc [6];
        logic       rs;
        logic [7:0] hr;
        exp_t       e;

        tbl[0] = '{1'b1, 8'd100, 8'd100, 8'hC8, 1'b1};
        tbl[1] = '{1'b0, 8'd100, 8'd100, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 8'h80,  8'h01,  8'h7F, 1'b1};
        tbl[3] = '{1'b1, 8'h00,  8'h00,  8'h00, 1'b0};
        tbl[4] = '{1'b1, 8'h7F,  8'h01,  8'h80, 1'b1};
        tbl[5] = '{1'b0, 8'h00,  8'h80,  8'h80, 1'b1};
        tbl[6] = '{1'b1, 8'h80,  8'h80,  8'h00, 1'b1};
        tbl[7] = '{1'b0, 8'hFF,  8'h7F,  8'h80, 1'b0};
        tbl[8] = '{1'b1, 8'hCE,  8'h14,  8'hE2, 1'b0};

        Reset    = 1'b1;
        InValid  = 1'b0;
        InMode   = 1'b0;
        InA      = '0;
        InB      = '0;
        OutReady = 1'b0;
        tick();
        tick();
        check_idle("reset");

        // First-op latency: push P, issue P+1, capture P+3, one-cycle valid.
        Reset    = 1'b0;
        OutReady = 1'b1;
        InValid  = 1'b1;
        InMode   = 1'b1;
        InA      = 8'd20;
        InB      = 8'd8;
        tick();
        InValid = 1'b0;
        chk("lat_p_count", int'(Count), 1);
        chk("lat_p_valid", int'(OutValid), 0);
        tick();
        chk("lat_p1_mode", int'(AddSubMode), 1);
        chk("lat_p1_opa", int'(OpA), 20);
        chk("lat_p1_opb", int'(OpB), 8);
        chk("lat_p1_count", int'(Count), 0);
        tick();
        chk("lat_p2_valid", int'(OutValid), 0);
        tick();
        chk("lat_p3_valid", int'(OutValid), 1);
        chk("lat_p3_result", int'(OutResult), 28);
        chk("lat_p3_ovf", int'(OutOverflow), 0);
        tick();
        chk("lat_p4_valid", int'(OutValid), 0);
        chk("lat_p4_opa_kept", int'(OpA), 20);

        // Directed vector table, back-to-back pushes, consumer always ready.
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    e.res = tbl[i].res;
                    e.ovf = tbl[i].ovf;
                    push_one(tbl[i].mode, tbl[i].a, tbl[i].b, e);
                end
            end
            collect(9, 1'b0);
        join

        // Stalled consumer: 6 offers, 1 issued + 4 queued, 6th refused.
        OutReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            InValid = 1'b1;
            InMode  = logic'(i % 2);
            InA     = 8'(10 * i + 1);
            InB     = 8'd3;
            rs      = InReady;
            tick();
            acc[i]  = rs;
            if (rs) exp_q.push_back(ref_op(logic'(i % 2), 8'(10 * i + 1), 8'd3));
        end
        InValid = 1'b0;
        chk("full_push4_accepted", int'(acc[4]), 1);
        chk("full_push5_refused", int'(acc[5]), 0);
        chk("full_count", int'(Count), 4);
        chk("full_inready", int'(InReady), 0);
        wait_valid("full_wait_valid");
        hr = OutResult;
        tick();
        tick();
        chk("stall_valid", int'(OutValid), 1);
        chk("stall_result", int'(OutResult), int'(hr));
        chk("stall_count", int'(Count), 4);

        // Pop and push on the same edge with FIFO full: push refused.
        InValid  = 1'b1;
        InMode   = 1'b1;
        InA      = 8'd99;
        InB      = 8'd99;
        OutReady = 1'b1;
        e = exp_q.pop_front();
        chk("full_pp_result", int'(OutResult), int'(e.res));
        chk("full_pp_ovf", int'(OutOverflow), int'(e.ovf));
        tick();
        InValid = 1'b0;
        chk("full_pp_count", int'(Count), 3);
        chk("full_pp_inready", int'(InReady), 1);
        chk("full_pp_valid", int'(OutValid), 0);
        collect(4, 1'b0);

        // Pop and push on the same edge with 2 entries: count unchanged.
        OutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_one(1'b0, 8'(i + 40), 8'(i), ref_op(1'b0, 8'(i + 40), 8'(i)));
        end
        chk("two_count", int'(Count), 2);
        wait_valid("two_wait_valid");
        e = exp_q.pop_front();
        chk("two_pp_result", int'(OutResult), int'(e.res));
        InValid  = 1'b1;
        InMode   = 1'b1;
        InA      = 8'd7;
        InB      = 8'd9;
        OutReady = 1'b1;
        rs       = InReady;
        tick();
        InValid = 1'b0;
        if (rs) exp_q.push_back(ref_op(1'b1, 8'd7, 8'd9));
        chk("two_pp_accepted", int'(rs), 1);
        chk("two_pp_count", int'(Count), 2);
        collect(3, 1'b0);

        // Reset while waiting on the unit: op discarded.
        OutReady = 1'b1;
        InValid  = 1'b1;
        InMode   = 1'b1;
        InA      = 8'd5;
        InB      = 8'd5;
        tick();
        InValid = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_idle("rst_wait");
        no_output_for("rst_wait_discard", 6);

        // Reset while holding a result with more queued behind it.
        OutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            InValid = 1'b1;
            InMode  = 1'b0;
            InA     = 8'(60 + i);
            InB     = 8'd1;
            tick();
        end
        InValid = 1'b0;
        wait_valid("rst_hold_wait_valid");
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_idle("rst_hold");
        OutReady = 1'b1;
        no_output_for("rst_hold_discard", 6);

        // Random traffic against the arithmetic reference.
        fork
            begin
                for (int k = 0; k < 80; k++) begin
                    logic       m;
                    logic [7:0] a;
                    logic [7:0] b;
                    int         gap;
                    gap = $urandom_range(0, 3);
                    for (int g = 0; g < gap; g++) tick();
                    m = 1'($urandom);
                    a = ($urandom_range(0, 4) == 0) ? 8'h80 : 8'($urandom);
                    b = ($urandom_range(0, 4) == 0) ? 8'h7F : 8'($urandom);
                    push_one(m, a, b, ref_op(m, a, b));
                end
            end
            collect(80, 1'b1);
        join

        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
